// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, the latched
// request record and the memory access size encodings.
package mmix_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_F = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        rd;
    logic        wr;
    logic [63:0] wdata;
  } mem_req_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WYDE  = 2'd1;
  localparam logic [1:0] SZ_TETRA = 2'd2;
  localparam logic [1:0] SZ_OCTA  = 2'd3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (F) and the
// exec-unit load/store path (D); one transaction in flight at a time.
module mem_port_arbiter
  import mmix_defs::*;
#(
  parameter bit          DATA_PRIO    = 1'b1,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] f_address,
  input  logic [1:0]  f_datasize,
  input  logic        f_read,
  output logic [63:0] f_readdata,
  output logic        f_done,
  input  logic [63:0] d_address,
  input  logic [1:0]  d_datasize,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_writedata,
  output logic [63:0] d_readdata,
  output logic        d_done,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  input  logic [63:0] mem_readdata,
  input  logic        mem_done,
  output logic        illegal
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
  localparam logic       RR_F    = 1'b0;
  localparam logic       RR_D    = 1'b1;

  arb_state_t state, state_next;
  mem_req_t   req;
  logic [3:0] run;
  logic       rr_ptr;
  logic       d_req;
  logic       grant_f, grant_d;
  logic       granted;

  // Grant decision and next state; requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    d_req      = d_read | d_write;
    case (state)
      IDLE: begin
        if (f_read && d_req) begin
          if (run == RUN_MAX)       grant_f = 1'b1;
          else if (DATA_PRIO)       grant_d = 1'b1;
          else if (rr_ptr == RR_F)  grant_f = 1'b1;
          else                      grant_d = 1'b1;
        end else if (f_read) begin
          grant_f = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_f) state_next = GRANT_F;
        if (grant_d) state_next = GRANT_D;
      end
      GRANT_F, GRANT_D: if (mem_done) state_next = RELEASE;
      RELEASE:          state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req        <= '0;
      run        <= '0;
      rr_ptr     <= RR_F;
      illegal    <= 1'b0;
      f_readdata <= '0;
      d_readdata <= '0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      state  <= state_next;
      f_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_f) begin
        req <= '{addr: f_address, size: f_datasize, rd: 1'b1, wr: 1'b0, wdata: '0};
        run <= '0;
        if (d_req) rr_ptr <= RR_D;
      end else if (grant_d) begin
        // A read+write request is performed as a write.
        req <= '{addr: d_address, size: d_datasize, rd: d_read & ~d_write,
                 wr: d_write, wdata: d_writedata};
        if (f_read) begin
          rr_ptr <= RR_F;
          if (run != RUN_MAX) run <= run + 4'd1;
        end else begin
          run <= '0;
        end
      end else if (state == IDLE && !f_read) begin
        run <= '0;
      end
      if (state == IDLE && d_read && d_write) illegal <= 1'b1;
      if (state == GRANT_F && mem_done) begin
        f_done     <= 1'b1;
        f_readdata <= mem_readdata;
      end
      if (state == GRANT_D && mem_done) begin
        d_done <= 1'b1;
        if (req.rd) d_readdata <= mem_readdata;
      end
    end
  end

  // The memory side only ever sees the latched request.
  assign granted       = (state == GRANT_F) || (state == GRANT_D);
  assign mem_read      = granted & req.rd;
  assign mem_write     = granted & req.wr;
  assign mem_address   = req.addr;
  assign mem_datasize  = req.size;
  assign mem_writedata = req.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized request mix checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import mmix_defs::*;

  localparam int MAX_RUN = 4;

  logic        clk, reset_n;
  logic [63:0] f_address, d_address, d_writedata, mem_readdata;
  logic [1:0]  f_datasize, d_datasize;
  logic        f_read, d_read, d_write, mem_done;
  logic [63:0] f_readdata, d_readdata, mem_address, mem_writedata;
  logic        f_done, d_done, mem_read, mem_write, illegal;
  logic [1:0]  mem_datasize;

  int checks = 0;
  int errors = 0;
  int f_done_cnt = 0;
  int d_done_cnt = 0;

  // Reference model: pending requests, expected read data, data-run length.
  bit          f_pend, d_pend;
  logic [63:0] f_addr_m, d_addr_m, d_wdata_m;
  logic [1:0]  f_size_m, d_size_m;
  bit          d_rd_m, d_wr_m;
  logic [63:0] f_rdata_exp, d_rdata_exp;
  int          data_run;
  int          obs_winner;

  mem_port_arbiter #(.DATA_PRIO(1'b1), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_address(f_address), .f_datasize(f_datasize), .f_read(f_read),
    .f_readdata(f_readdata), .f_done(f_done),
    .d_address(d_address), .d_datasize(d_datasize), .d_read(d_read),
    .d_write(d_write), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_done(d_done),
    .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done), .illegal(illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (f_done) f_done_cnt++;
    if (d_done) d_done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic set_f(input logic [63:0] a, input logic [1:0] s);
    f_addr_m = a; f_size_m = s; f_pend = 1;
    f_address = a; f_datasize = s; f_read = 1'b1;
  endtask

  task automatic set_d(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [1:0] s, input logic [63:0] wd);
    d_rd_m = rd; d_wr_m = wr; d_addr_m = a; d_size_m = s; d_wdata_m = wd; d_pend = 1;
    d_read = rd; d_write = wr; d_address = a; d_datasize = s; d_writedata = wd;
  endtask

  task automatic clear_f();
    f_pend = 0; f_read = 1'b0;
  endtask

  task automatic clear_d();
    d_pend = 0; d_read = 1'b0; d_write = 1'b0;
  endtask

  // One complete transaction: predict the winner, act as memory, check the port.
  task automatic txn(input int lat, input bit drop_f, input bit drop_d, input logic [63:0] rdata);
    bit exp_d, erd, ewr;
    logic [63:0] ea, ewd;
    logic [1:0] es;
    if (f_pend && d_pend) exp_d = (data_run < MAX_RUN);
    else exp_d = d_pend;
    if (exp_d) begin
      ea = d_addr_m; es = d_size_m; ewr = d_wr_m; erd = d_rd_m && !d_wr_m; ewd = d_wdata_m;
      if (f_pend) data_run = (data_run < MAX_RUN) ? data_run + 1 : data_run;
      else data_run = 0;
    end else begin
      ea = f_addr_m; es = f_size_m; erd = 1; ewr = 0; ewd = '0;
      data_run = 0;
    end
    tick();
    checks++;
    if (!(mem_read || mem_write)) begin
      errors++;
      $display("FAIL grant_latency: got mem_read=%0b mem_write=%0b, expected an access one cycle after the request", mem_read, mem_write);
      for (int i = 0; i < 20 && !(mem_read || mem_write); i++) tick();
      if (!(mem_read || mem_write)) begin
        errors++;
        $display("FAIL grant_timeout: got no memory access after 20 cycles, expected one");
        return;
      end
    end
    checks++;
    if (mem_address !== ea || mem_datasize !== es) begin
      errors++;
      $display("FAIL mem_addr: got %h/%0d expected %h/%0d", mem_address, mem_datasize, ea, es);
    end
    checks++;
    if (mem_read !== erd || mem_write !== ewr) begin
      errors++;
      $display("FAIL mem_cmd: got rd=%0b wr=%0b expected rd=%0b wr=%0b", mem_read, mem_write, erd, ewr);
    end
    if (ewr) begin
      checks++;
      if (mem_writedata !== ewd) begin
        errors++;
        $display("FAIL mem_wdata: got %h expected %h", mem_writedata, ewd);
      end
    end
    for (int i = 1; i < lat; i++) begin
      if (exp_d) begin
        d_address = rand64(); d_writedata = rand64();
      end else begin
        f_address = rand64();
      end
      tick();
      checks++;
      if (mem_address !== ea || mem_read !== erd || mem_write !== ewr ||
          (ewr && mem_writedata !== ewd)) begin
        errors++;
        $display("FAIL hold_stable: got a=%h rd=%0b wr=%0b wd=%h expected a=%h rd=%0b wr=%0b wd=%h",
                 mem_address, mem_read, mem_write, mem_writedata, ea, erd, ewr, ewd);
      end
    end
    mem_readdata = rdata;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    mem_readdata = rand64();
    if (exp_d && erd) d_rdata_exp = rdata;
    if (!exp_d) f_rdata_exp = rdata;
    obs_winner = d_done ? 1 : (f_done ? 0 : -1);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL mem_drop: got rd=%0b wr=%0b expected 0 0", mem_read, mem_write);
    end
    checks++;
    if (f_done !== !exp_d || d_done !== exp_d) begin
      errors++;
      $display("FAIL done_pulse: got f_done=%0b d_done=%0b expected %0b %0b", f_done, d_done, !exp_d, exp_d);
    end
    checks++;
    if (f_readdata !== f_rdata_exp || d_readdata !== d_rdata_exp) begin
      errors++;
      $display("FAIL readdata: got f=%h d=%h expected f=%h d=%h", f_readdata, d_readdata, f_rdata_exp, d_rdata_exp);
    end
    // Requester reaction during the release cycle: drop, or renew the original request.
    if (exp_d) begin
      if (drop_d) clear_d();
      else set_d(d_rd_m, d_wr_m, d_addr_m, d_size_m, d_wdata_m);
    end else begin
      if (drop_f) clear_f();
      else set_f(f_addr_m, f_size_m);
    end
    tick();
    checks++;
    if (f_done !== 1'b0 || d_done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL release: got f_done=%0b d_done=%0b rd=%0b wr=%0b expected all 0",
               f_done, d_done, mem_read, mem_write);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (f_done !== 0 || d_done !== 0 || mem_read !== 0 || mem_write !== 0 || illegal !== 0 ||
        mem_address !== 0 || mem_datasize !== 0 || mem_writedata !== 0 ||
        f_readdata !== 0 || d_readdata !== 0) begin
      errors++;
      $display("FAIL %s: got done=%0b%0b rd=%0b wr=%0b ill=%0b a=%h wd=%h fr=%h dr=%h expected all 0",
               tag, f_done, d_done, mem_read, mem_write, illegal, mem_address, mem_writedata,
               f_readdata, d_readdata);
    end
  endtask

  task automatic test_reset();
    f_read = 0; d_read = 0; d_write = 0; mem_done = 0;
    f_address = 0; f_datasize = 0; d_address = 0; d_datasize = 0;
    d_writedata = 0; mem_readdata = 0;
    f_pend = 0; d_pend = 0; data_run = 0; f_rdata_exp = 0; d_rdata_exp = 0;
    reset_n = 0;
    repeat (3) tick();
    check_all_zero("reset_held");
    reset_n = 1;
    tick();
    check_all_zero("reset_released");
  endtask

  task automatic test_single_f();
    set_f(64'h8000_0000_0000_0000, SZ_TETRA);
    txn(3, 1, 1, 64'h1122_3344_5566_7788);
  endtask

  task automatic test_contention();
    int fc0, dc0;
    fc0 = f_done_cnt; dc0 = d_done_cnt;
    set_f(rand64(), SZ_OCTA);
    set_d(1, 0, rand64(), SZ_WYDE, 64'h0);
    txn(2, 1, 1, rand64());
    checks++;
    if (obs_winner !== 1) begin
      errors++;
      $display("FAIL contention_first: got winner %0d expected 1 (D)", obs_winner);
    end
    txn(1, 1, 1, rand64());
    checks++;
    if (obs_winner !== 0) begin
      errors++;
      $display("FAIL contention_second: got winner %0d expected 0 (F)", obs_winner);
    end
    checks++;
    if (f_done_cnt - fc0 !== 1 || d_done_cnt - dc0 !== 1) begin
      errors++;
      $display("FAIL contention_done_count: got f=%0d d=%0d expected 1 1", f_done_cnt - fc0, d_done_cnt - dc0);
    end
  endtask

  task automatic test_starvation();
    int order [6];
    int expect_order [6];
    expect_order = '{1, 1, 1, 1, 0, 1};
    set_f(rand64(), SZ_OCTA);
    for (int i = 0; i < 6; i++) begin
      if (!d_pend) set_d(1, 0, rand64(), SZ_OCTA, 64'h0);
      txn($urandom_range(1, 3), 0, 1, rand64());
      order[i] = obs_winner;
    end
    clear_f();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (order[i] !== expect_order[i]) begin
        errors++;
        $display("FAIL starvation_order[%0d]: got %0d expected %0d", i, order[i], expect_order[i]);
      end
    end
  endtask

  task automatic test_store();
    set_d(0, 1, 64'h0000_0000_0000_1000, SZ_OCTA, 64'hDEAD_BEEF_0123_4567);
    txn(4, 1, 1, 64'hFFFF_0000_FFFF_0000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if (!f_pend && $urandom_range(0, 9) < 6) set_f(rand64(), 2'($urandom_range(0, 3)));
      if (!d_pend && $urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 1) == 1) set_d(1, 0, rand64(), 2'($urandom_range(0, 3)), 64'h0);
        else set_d(0, 1, rand64(), 2'($urandom_range(0, 3)), rand64());
      end
      if (!f_pend && !d_pend) set_f(rand64(), 2'($urandom_range(0, 3)));
      txn($urandom_range(1, 5), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rand64());
    end
    for (int n = 0; n < 4 && (f_pend || d_pend); n++) txn(1, 1, 1, rand64());
  endtask

  task automatic test_illegal();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_before: got %0b expected 0", illegal);
    end
    set_d(1, 1, rand64(), SZ_TETRA, rand64());
    txn(2, 1, 1, rand64());
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set: got %0b expected 1", illegal);
    end
    set_f(rand64(), SZ_BYTE);
    txn(1, 1, 1, rand64());
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got %0b expected 1", illegal);
    end
  endtask

  task automatic test_reset_mid_grant();
    int fc0, dc0;
    set_d(1, 0, rand64(), SZ_OCTA, 64'h0);
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: got mem_read=%0b expected 1", mem_read);
    end
    tick();
    reset_n = 0;
    #1;
    check_all_zero("reset_mid_grant");
    clear_d();
    data_run = 0; f_rdata_exp = 0; d_rdata_exp = 0;
    fc0 = f_done_cnt; dc0 = d_done_cnt;
    tick();
    reset_n = 1;
    tick();
    mem_readdata = rand64();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    repeat (3) tick();
    check_all_zero("spurious_done");
    checks++;
    if (f_done_cnt !== fc0 || d_done_cnt !== dc0) begin
      errors++;
      $display("FAIL no_done_after_reset: got f=%0d d=%0d pulses expected 0 0", f_done_cnt - fc0, d_done_cnt - dc0);
    end
    set_f(rand64(), SZ_WYDE);
    txn(2, 1, 1, rand64());
  endtask

  initial begin
    test_reset();
    test_single_f();
    test_contention();
    test_starvation();
    test_store();
    test_random();
    test_illegal();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
